// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: ISA widths, opcode constants, fetch entry type.
// Optional build macro honoured by the fetch logic: FETCH_DELAY_SLOT_EN.
package fetch_unit_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, decode handshake, redirect path.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic [31:0]        imem_addr;
  logic               imem_rd_en;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [31:0]        out_pc;
  logic               redirect_valid;
  logic [31:0]        redirect_target;

  modport master (
    output imem_addr, imem_rd_en, out_valid, out_instr, out_pc,
    input  imem_rdata, out_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_addr, imem_rd_en, out_valid, out_instr, out_pc,
    output imem_rdata, out_ready, redirect_valid, redirect_target
  );

endinterface

// File: rtl/fetch_unit_skid.sv
// One-entry {instr, pc} holding buffer that catches a memory reply while decode stalls.
module fetch_unit_skid
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         drain,
  input  logic         squash,
  input  fetch_entry_t din,
  output logic         valid,
  output fetch_entry_t dout
);

  logic         valid_r;
  fetch_entry_t entry_r;

  // Occupancy flag and stored entry; drain or squash empties, load fills.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      entry_r <= '{instr: 32'h0000_0000, pc: 32'h0000_0000};
    end else begin
      if (squash || drain) begin
        valid_r <= 1'b0;
      end else if (load) begin
        valid_r <= 1'b1;
      end
      if (load) begin
        entry_r <= din;
      end
    end
  end

  assign valid = valid_r;
  assign dout  = entry_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle imem request tracking, skid-backed output to decode.
// Build option FETCH_DELAY_SLOT_EN keeps the instruction after a redirecting one.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  logic [31:0]  pc_r;
  logic [31:0]  req_pc_r;
  logic         inflight_r;
  logic         out_valid_r;
  fetch_entry_t out_entry_r;

  logic         accept_s;
  logic         redirect_s;
  logic         out_free_s;
  logic         issue_s;
  logic         skid_load_s;
  logic         skid_drain_s;
  logic         skid_valid_s;
  fetch_entry_t skid_entry_s;
  fetch_entry_t reply_entry_s;
  logic         out_valid_next_s;
  fetch_entry_t out_next_s;
  logic [31:0]  pc_next_s;

  fetch_unit_skid u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load_s),
    .drain  (skid_drain_s),
    .squash (redirect_s),
    .din    (reply_entry_s),
    .valid  (skid_valid_s),
    .dout   (skid_entry_s)
  );

  // Handshake decode, request gating and output/skid steering.
  always_comb begin
    accept_s      = out_valid_r & bus.out_ready;
    redirect_s    = accept_s & bus.redirect_valid;
    out_free_s    = ~out_valid_r | accept_s;
    // The redirect cycle issues nothing: pc is stale until the target loads.
    issue_s       = ~reset & out_free_s & ~redirect_s;
    reply_entry_s = '{instr: bus.imem_rdata, pc: req_pc_r};
    skid_load_s   = ~out_free_s & inflight_r;
    skid_drain_s  = accept_s & skid_valid_s;

    out_valid_next_s = out_valid_r;
    out_next_s       = out_entry_r;
    if (out_free_s) begin
      if (redirect_s) begin
`ifdef FETCH_DELAY_SLOT_EN
        if (skid_valid_s) begin
          out_valid_next_s = 1'b1;
          out_next_s       = skid_entry_s;
        end else if (inflight_r) begin
          out_valid_next_s = 1'b1;
          out_next_s       = reply_entry_s;
        end else begin
          out_valid_next_s = 1'b0;
        end
`else
        out_valid_next_s = 1'b0;
`endif
      end else if (skid_valid_s) begin
        out_valid_next_s = 1'b1;
        out_next_s       = skid_entry_s;
      end else if (inflight_r) begin
        out_valid_next_s = 1'b1;
        out_next_s       = reply_entry_s;
      end else begin
        out_valid_next_s = 1'b0;
      end
    end else begin
      out_valid_next_s = out_valid_r;
    end

    if (redirect_s) begin
      pc_next_s = word_align(bus.redirect_target);
    end else if (issue_s) begin
      pc_next_s = pc_r + 32'd4;
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC, request tracking and output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r        <= RESET_PC;
      req_pc_r    <= 32'h0000_0000;
      inflight_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_entry_r <= '{instr: 32'h0000_0000, pc: 32'h0000_0000};
    end else begin
      pc_r        <= pc_next_s;
      inflight_r  <= issue_s;
      if (issue_s) begin
        req_pc_r <= pc_r;
      end
      out_valid_r <= out_valid_next_s;
      out_entry_r <= out_next_s;
    end
  end

  assign bus.imem_addr  = pc_r;
  assign bus.imem_rd_en = issue_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_instr  = out_entry_r.instr;
  assign bus.out_pc     = out_entry_r.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random handshake/redirect
// traffic checked against a program-order stream model. Honours FETCH_DELAY_SLOT_EN.
module tb_fetch_unit;

  logic clk;
  logic reset;

  fetch_unit_if bus_if ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] salt;

  // Synchronous instruction memory: word = address xor salt, one cycle later.
  always @(posedge clk) begin
    if (bus_if.imem_rd_en) begin
      bus_if.imem_rdata <= bus_if.imem_addr ^ salt;
    end
  end

  int          checks;
  int          errors;
  logic [31:0] exp_pc;
  logic [31:0] pend_tgt;
  logic [31:0] post_tgt;
  bit          pending;
  bit          post_redirect;
  bit          expect_full;
  int          idle;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_init();
    exp_pc        = 32'h0000_0000;
    pending       = 1'b0;
    post_redirect = 1'b0;
    idle          = 0;
  endtask

  task automatic do_reset(input logic [31:0] new_salt);
    reset                  = 1'b1;
    bus_if.out_ready       = 1'b0;
    bus_if.redirect_valid  = 1'b0;
    bus_if.redirect_target = 32'h0000_0000;
    salt                   = new_salt;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("rst_rd_en", {31'd0, bus_if.imem_rd_en}, 32'd0);
    check("rst_out_pc", bus_if.out_pc, 32'd0);
    check("rst_out_instr", bus_if.out_instr, 32'd0);
    reset = 1'b0;
    model_init();
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    #1;
    check("async_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check("async_rd_en", {31'd0, bus_if.imem_rd_en}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_init();
  endtask

  // One clock: drive inputs, sample at the falling edge, advance the stream model.
  task automatic cycle(input bit rdy, input bit rv, input logic [31:0] tgt);
    bit v;
    bit acc;
    bit rv_eff;
    rv_eff = rv && !pending;
    bus_if.out_ready       = rdy;
    bus_if.redirect_valid  = rv_eff;
    bus_if.redirect_target = tgt;
    @(negedge clk);
    v   = bus_if.out_valid;
    acc = v && rdy;
    if (v) begin
      check("out_pc", bus_if.out_pc, exp_pc);
      check("out_instr", bus_if.out_instr, exp_pc ^ salt);
      if (!rdy) check("rd_en_stall", {31'd0, bus_if.imem_rd_en}, 32'd0);
    end
    if (expect_full) check("throughput", {31'd0, v}, 32'd1);
    if (post_redirect) begin
      check("redir_addr", bus_if.imem_addr, post_tgt);
`ifdef FETCH_DELAY_SLOT_EN
      check("delay_slot_valid", {31'd0, v}, 32'd1);
`else
      check("redir_bubble", {31'd0, v}, 32'd0);
`endif
      post_redirect = 1'b0;
    end
    idle = v ? 0 : idle + 1;
    check("no_starve", {31'd0, (idle <= 4)}, 32'd1);
    if (acc) begin
      if (rv_eff) begin
        post_redirect = 1'b1;
        post_tgt      = tgt & 32'hFFFF_FFFC;
`ifdef FETCH_DELAY_SLOT_EN
        exp_pc   = exp_pc + 32'd4;
        pend_tgt = tgt & 32'hFFFF_FFFC;
        pending  = 1'b1;
`else
        exp_pc = tgt & 32'hFFFF_FFFC;
`endif
      end else if (pending) begin
        exp_pc  = pend_tgt;
        pending = 1'b0;
      end else begin
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    checks      = 0;
    errors      = 0;
    expect_full = 1'b0;
    salt        = 32'h0000_0000;
    reset       = 1'b1;
    model_init();

    // Streaming from reset, memory returns the address itself.
    do_reset(32'h0000_0000);
    cycle(1'b1, 1'b0, 32'd0);
    check("second_req_addr", bus_if.imem_addr, 32'd4);
    check("no_early_valid", {31'd0, bus_if.out_valid}, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    expect_full = 1'b1;
    repeat (8) cycle(1'b1, 1'b0, 32'd0);
    expect_full = 1'b0;

    // Stall three cycles with pc 8 presented, then release.
    do_reset(32'h1357_0000);
    repeat (2) cycle(1'b1, 1'b0, 32'd0);
    expect_full = 1'b1;
    repeat (2) cycle(1'b1, 1'b0, 32'd0);
    check("stall_head", bus_if.out_pc, 32'd8);
    repeat (3) cycle(1'b0, 1'b0, 32'd0);
    repeat (4) cycle(1'b1, 1'b0, 32'd0);
    expect_full = 1'b0;

    // Redirect from pc 0x10 to an unaligned target.
    do_reset(32'hC0DE_0000);
    repeat (6) cycle(1'b1, 1'b0, 32'd0);
    check("redir_src", bus_if.out_pc, 32'h10);
    cycle(1'b1, 1'b1, 32'h0000_0103);
    repeat (5) cycle(1'b1, 1'b0, 32'd0);

    // Redirect while the skid is full, then a redirect that wraps the address space.
    do_reset(32'hBEEF_0000);
    repeat (3) cycle(1'b1, 1'b0, 32'd0);
    repeat (2) cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'h0000_0200);
    repeat (4) cycle(1'b1, 1'b0, 32'd0);
    cycle(1'b1, 1'b1, 32'hFFFF_FFF9);
    repeat (7) cycle(1'b1, 1'b0, 32'd0);

    // Reset with a reply in flight, and again with the skid full.
    repeat (3) cycle(1'b1, 1'b0, 32'd0);
    mid_reset();
    repeat (5) cycle(1'b1, 1'b0, 32'd0);
    repeat (2) cycle(1'b0, 1'b0, 32'd0);
    mid_reset();
    repeat (5) cycle(1'b1, 1'b0, 32'd0);

    // Random handshake and redirect traffic.
    do_reset(32'h5A5A_A5A5);
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      cycle($urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0,
            ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | (r & 32'h0000_000F)) : r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
